// File: rtl/ps2_keyboard_event_decoder.sv
// ps2_keyboard_event_decoder
//   Turns the PS/2 scan-code byte stream into make/break events (with E0
//   extended prefix), tracks modifier and lock state, queues events in a
//   first-word-fall-through FIFO and refreshes the keyboard lock LEDs through
//   the controller's command handshake.
// Ports:
//   sys_Clk, Reset            clock, synchronous active-low reset
//   rx_data, rx_valid         received byte + one-cycle strobe
//   cmd_byte, cmd_send        command byte + level request to the controller
//   cmd_sent                  one-cycle strobe, command transmitted
//   ev_data, ev_empty, ev_pop event FIFO head {shift,ctrl,alt,caps,brk,ext,code}
//   ev_full, ev_overflow      FIFO full / sticky dropped-event flag
//   shift, ctrl, alt          modifier held (left OR right)
//   caps_lock, num_lock, scroll_lock  lock toggle state
//   led_error                 sticky LED transfer timeout
module ps2_keyboard_event_decoder #(
    parameter int FIFO_DEPTH  = 8,
    parameter int REPORT_MAKE = 1,
    parameter int LED_UPDATE  = 1,
    parameter int ACK_TIMEOUT = 50000
) (
    input  logic        sys_Clk,
    input  logic        Reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  cmd_byte,
    output logic        cmd_send,
    input  logic        cmd_sent,
    output logic [13:0] ev_data,
    output logic        ev_empty,
    input  logic        ev_pop,
    output logic        ev_full,
    output logic        ev_overflow,
    output logic        shift,
    output logic        ctrl,
    output logic        alt,
    output logic        caps_lock,
    output logic        num_lock,
    output logic        scroll_lock,
    output logic        led_error
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    // Modifier slots: 0 lshift, 1 rshift, 2 lctrl, 3 rctrl, 4 lalt, 5 ralt
    localparam logic [47:0] MOD_CODES = {8'h11, 8'h11, 8'h14, 8'h14, 8'h59, 8'h12};
    localparam logic [5:0]  MOD_EXT   = 6'b101000;
    // Lock slots: 2 caps, 1 num, 0 scroll
    localparam logic [23:0] LOCK_CODES = {8'h58, 8'h77, 8'h7E};

    typedef enum logic [1:0] {P_IDLE, P_EXT, P_BRK, P_EXT_BRK} p_state_t;
    typedef enum logic [2:0] {L_IDLE, L_CMD, L_ACK1, L_DATA, L_ACK2} l_state_t;

    p_state_t p_state_reg, p_state_next;
    l_state_t l_state_reg;

    logic [5:0] mod_reg, mod_next;
    logic [2:0] lock_reg, lock_next;
    logic [2:0] held_reg, held_next;
    logic [5:0] mod_hit;
    logic [2:0] lock_hit;
    logic       toggle;
    logic       pending_reg;
    logic [TW-1:0] timer_reg;

    logic is_e0, is_f0, is_ctl, bat, ack, is_event, brk, ext;
    logic [13:0] ev_word;
    logic        push, do_push, do_pop;

    logic [13:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;

    // ---------------- byte classification ----------------
    assign is_e0    = (rx_data == 8'hE0);
    assign is_f0    = (rx_data == 8'hF0);
    assign is_ctl   = rx_data inside {8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};
    assign bat      = rx_valid && (rx_data == 8'hAA);
    assign ack      = rx_valid && (rx_data == 8'hFA);
    assign is_event = rx_valid && !is_e0 && !is_f0 && !is_ctl && (rx_data != 8'hAA);
    assign brk      = (p_state_reg == P_BRK) || (p_state_reg == P_EXT_BRK);
    assign ext      = (p_state_reg == P_EXT) || (p_state_reg == P_EXT_BRK);

    always_comb begin
        p_state_next = p_state_reg;
        if (rx_valid) begin
            if (is_e0)
                p_state_next = P_EXT;
            else if (is_f0)
                p_state_next = ext ? P_EXT_BRK : P_BRK;
            else
                p_state_next = P_IDLE;
        end
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_mod
            assign mod_hit[gi] = is_event && (rx_data == MOD_CODES[gi*8 +: 8])
                                 && (ext == MOD_EXT[gi]);
        end
        for (genvar gi = 0; gi < 3; gi++) begin : g_lock
            assign lock_hit[gi] = is_event && !ext && (rx_data == LOCK_CODES[gi*8 +: 8]);
        end
    endgenerate

    // Post-update modifier/lock state; the event word carries these values.
    always_comb begin
        mod_next  = mod_reg;
        lock_next = lock_reg;
        held_next = held_reg;
        toggle    = 1'b0;
        if (bat) begin
            mod_next  = '0;
            lock_next = '0;
            held_next = '0;
        end else begin
            for (int i = 0; i < 6; i++)
                if (mod_hit[i]) mod_next[i] = !brk;
            for (int i = 0; i < 3; i++) begin
                if (lock_hit[i]) begin
                    if (brk) begin
                        held_next[i] = 1'b0;
                    end else if (!held_reg[i]) begin
                        // first make toggles; typematic repeats are ignored
                        held_next[i] = 1'b1;
                        lock_next[i] = !lock_reg[i];
                        toggle       = 1'b1;
                    end
                end
            end
        end
    end

    assign ev_word = {mod_next[0] | mod_next[1], mod_next[2] | mod_next[3],
                      mod_next[4] | mod_next[5], lock_next[2], brk, ext, rx_data};
    assign push    = is_event && (brk || (REPORT_MAKE != 0));

    always_ff @(posedge sys_Clk) begin
        if (!Reset) begin
            p_state_reg <= P_IDLE;
            mod_reg     <= '0;
            lock_reg    <= '0;
            held_reg    <= '0;
        end else begin
            p_state_reg <= p_state_next;
            mod_reg     <= mod_next;
            lock_reg    <= lock_next;
            held_reg    <= held_next;
        end
    end

    assign shift       = mod_reg[0] | mod_reg[1];
    assign ctrl        = mod_reg[2] | mod_reg[3];
    assign alt         = mod_reg[4] | mod_reg[5];
    assign caps_lock   = lock_reg[2];
    assign num_lock    = lock_reg[1];
    assign scroll_lock = lock_reg[0];

    // ---------------- event FIFO (first word fall through) ----------------
    assign ev_empty = (count_reg == '0);
    assign ev_full  = (count_reg == CW'(FIFO_DEPTH));
    assign do_pop   = ev_pop && !ev_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push  = push && (!ev_full || do_pop);
    assign ev_data  = ev_empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge sys_Clk) begin
        if (do_push) mem[wr_ptr_reg] <= ev_word;
    end

    always_ff @(posedge sys_Clk) begin
        if (!Reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            ev_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)
                count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push)
                count_reg <= count_reg - 1'b1;
            if (do_pop)
                ev_overflow <= 1'b0;
            else if (push && !do_push)
                ev_overflow <= 1'b1;
        end
    end

    // ---------------- LED update FSM ----------------
    always_ff @(posedge sys_Clk) begin
        if (!Reset) begin
            l_state_reg <= L_IDLE;
            pending_reg <= 1'b0;
            timer_reg   <= '0;
            cmd_byte    <= '0;
            cmd_send    <= 1'b0;
            led_error   <= 1'b0;
        end else if (bat || (LED_UPDATE == 0)) begin
            l_state_reg <= L_IDLE;
            pending_reg <= 1'b0;
            timer_reg   <= '0;
            cmd_send    <= 1'b0;
        end else begin
            pending_reg <= pending_reg | toggle;
            case (l_state_reg)
                L_IDLE: begin
                    if (pending_reg) begin
                        pending_reg <= toggle;
                        l_state_reg <= L_CMD;
                        cmd_byte    <= 8'hED;
                        cmd_send    <= 1'b1;
                    end
                end
                L_CMD: begin
                    if (cmd_sent) begin
                        cmd_send    <= 1'b0;
                        timer_reg   <= '0;
                        l_state_reg <= L_ACK1;
                    end
                end
                L_ACK1: begin
                    if (ack) begin
                        cmd_byte    <= {5'b0, lock_reg};
                        cmd_send    <= 1'b1;
                        l_state_reg <= L_DATA;
                    end else if (timer_reg == TW'(ACK_TIMEOUT - 1)) begin
                        led_error   <= 1'b1;
                        l_state_reg <= L_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                L_DATA: begin
                    if (cmd_sent) begin
                        cmd_send    <= 1'b0;
                        timer_reg   <= '0;
                        l_state_reg <= L_ACK2;
                    end
                end
                L_ACK2: begin
                    if (ack) begin
                        l_state_reg <= L_IDLE;
                    end else if (timer_reg == TW'(ACK_TIMEOUT - 1)) begin
                        led_error   <= 1'b1;
                        l_state_reg <= L_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: l_state_reg <= L_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_event_decoder.sv
// Directed bench for ps2_keyboard_event_decoder. Instance a: report makes,
// depth 8, LED FSM on. Instance b: breaks only, depth 4, LED FSM off.
// Expected events are queued when bytes are driven and compared on pop.
module tb_ps2_keyboard_event_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset = 1'b0;
    int          compared = 0;
    int          mismatched = 0;
    logic [13:0] qa[$];
    logic [13:0] qb[$];

    // instance a
    logic [7:0]  rx_data_a = '0, cmd_byte_a;
    logic        rx_valid_a = 0, cmd_send_a, cmd_sent_a = 0, ev_empty_a, ev_pop_a = 0;
    logic        ev_full_a, ev_overflow_a, shift_a, ctrl_a, alt_a;
    logic        caps_a, num_a, scroll_a, led_error_a;
    logic [13:0] ev_data_a;
    // instance b
    logic [7:0]  rx_data_b = '0, cmd_byte_b;
    logic        rx_valid_b = 0, cmd_send_b, cmd_sent_b = 0, ev_empty_b, ev_pop_b = 0;
    logic        ev_full_b, ev_overflow_b, shift_b, ctrl_b, alt_b;
    logic        caps_b, num_b, scroll_b, led_error_b;
    logic [13:0] ev_data_b;

    ps2_keyboard_event_decoder #(.FIFO_DEPTH(8), .REPORT_MAKE(1), .LED_UPDATE(1),
                                 .ACK_TIMEOUT(20)) dut_a (
        .sys_Clk(clk), .Reset(Reset), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .cmd_byte(cmd_byte_a), .cmd_send(cmd_send_a), .cmd_sent(cmd_sent_a),
        .ev_data(ev_data_a), .ev_empty(ev_empty_a), .ev_pop(ev_pop_a),
        .ev_full(ev_full_a), .ev_overflow(ev_overflow_a), .shift(shift_a),
        .ctrl(ctrl_a), .alt(alt_a), .caps_lock(caps_a), .num_lock(num_a),
        .scroll_lock(scroll_a), .led_error(led_error_a));

    ps2_keyboard_event_decoder #(.FIFO_DEPTH(4), .REPORT_MAKE(0), .LED_UPDATE(0),
                                 .ACK_TIMEOUT(20)) dut_b (
        .sys_Clk(clk), .Reset(Reset), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .cmd_byte(cmd_byte_b), .cmd_send(cmd_send_b), .cmd_sent(cmd_sent_b),
        .ev_data(ev_data_b), .ev_empty(ev_empty_b), .ev_pop(ev_pop_b),
        .ev_full(ev_full_b), .ev_overflow(ev_overflow_b), .shift(shift_b),
        .ctrl(ctrl_b), .alt(alt_b), .caps_lock(caps_b), .num_lock(num_b),
        .scroll_lock(scroll_b), .led_error(led_error_b));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_a(input logic [7:0] b);
        rx_data_a = b; rx_valid_a = 1'b1;
        tick();
        rx_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        rx_data_b = b; rx_valid_b = 1'b1;
        tick();
        rx_valid_b = 1'b0;
    endtask

    task automatic pop_a(input string tag);
        logic [13:0] exp;
        exp = (qa.size() != 0) ? qa.pop_front() : 14'h0;
        check({tag, "_nonempty"}, 16'(ev_empty_a), 16'h0);
        check(tag, 16'(ev_data_a), 16'(exp));
        $display("a pop %s data=0x%03h exp=0x%03h", tag, ev_data_a, exp);
        ev_pop_a = 1'b1;
        tick();
        ev_pop_a = 1'b0;
    endtask

    task automatic pop_b(input string tag);
        logic [13:0] exp;
        exp = (qb.size() != 0) ? qb.pop_front() : 14'h0;
        check({tag, "_nonempty"}, 16'(ev_empty_b), 16'h0);
        check(tag, 16'(ev_data_b), 16'(exp));
        $display("b pop %s data=0x%03h exp=0x%03h", tag, ev_data_b, exp);
        ev_pop_b = 1'b1;
        tick();
        ev_pop_b = 1'b0;
    endtask

    // Bounded wait for the LED request, then check the byte offered.
    task automatic wait_cmd_a(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 100 && !cmd_send_a; i++) tick();
        check({tag, "_send"}, 16'(cmd_send_a), 16'h1);
        check({tag, "_byte"}, 16'(cmd_byte_a), 16'(exp));
        $display("a led cmd %s byte=0x%02h", tag, cmd_byte_a);
    endtask

    task automatic sent_a(input string tag);
        cmd_sent_a = 1'b1;
        tick();
        cmd_sent_a = 1'b0;
        check({tag, "_drop"}, 16'(cmd_send_a), 16'h0);
    endtask

    initial begin
        // ---- reset ----
        Reset = 1'b0;
        repeat (2) tick();
        check("rst_empty_a", 16'(ev_empty_a), 16'h1);
        check("rst_data_a", 16'(ev_data_a), 16'h0);
        check("rst_mods_a", 16'({shift_a, ctrl_a, alt_a, caps_a, num_a, scroll_a}), 16'h0);
        check("rst_led_a", 16'({cmd_send_a, led_error_a, ev_full_a, ev_overflow_a}), 16'h0);
        check("rst_empty_b", 16'(ev_empty_b), 16'h1);
        Reset = 1'b1;
        tick();

        // ---- make/break ----
        send_a(8'h1C); qa.push_back(14'h01C);
        send_a(8'hF0); send_a(8'h1C); qa.push_back(14'h21C);
        pop_a("t1_make");
        pop_a("t1_brk");
        check("t1_empty", 16'(ev_empty_a), 16'h1);

        // ---- shift around a key, extended ctrl ----
        send_a(8'h12); qa.push_back(14'h2012);
        check("t3_shift_on", 16'(shift_a), 16'h1);
        send_a(8'h1C); qa.push_back(14'h201C);
        send_a(8'hF0); send_a(8'h1C); qa.push_back(14'h221C);
        send_a(8'hF0); send_a(8'h12); qa.push_back(14'h0212);
        check("t3_shift_off", 16'(shift_a), 16'h0);
        send_a(8'hE0); send_a(8'h14); qa.push_back(14'h1114);
        check("t3_rctrl_on", 16'(ctrl_a), 16'h1);
        send_a(8'hE0); send_a(8'hF0); send_a(8'h14); qa.push_back(14'h0314);
        check("t3_rctrl_off", 16'(ctrl_a), 16'h0);
        for (int i = 0; i < 6; i++) pop_a($sformatf("t3_ev%0d", i));

        // ---- caps lock with typematic repeat and LED transfer ----
        send_a(8'h58); qa.push_back(14'h0458);
        check("t4_caps_on", 16'(caps_a), 16'h1);
        send_a(8'h58); qa.push_back(14'h0458);
        send_a(8'hF0); send_a(8'h58); qa.push_back(14'h0658);
        check("t4_caps_once", 16'(caps_a), 16'h1);
        wait_cmd_a("t4_ed", 8'hED);
        sent_a("t4_ed");
        send_a(8'hFA);
        wait_cmd_a("t4_data", 8'h04);
        sent_a("t4_data");
        send_a(8'hFA);
        repeat (5) tick();
        check("t4_no_resend", 16'(cmd_send_a), 16'h0);
        check("t4_led_error", 16'(led_error_a), 16'h0);
        for (int i = 0; i < 3; i++) pop_a($sformatf("t4_ev%0d", i));

        // ---- ack timeout, then BAT clears state but keeps FIFO ----
        send_a(8'h77); qa.push_back(14'h0477);
        check("t5_num_on", 16'(num_a), 16'h1);
        wait_cmd_a("t5_ed", 8'hED);
        sent_a("t5_ed");
        repeat (25) tick();
        check("t5_led_error", 16'(led_error_a), 16'h1);
        check("t5_send_low", 16'(cmd_send_a), 16'h0);
        send_a(8'hF0);
        send_a(8'hAA);
        check("t5_locks_clr", 16'({caps_a, num_a, scroll_a}), 16'h0);
        check("t5_err_sticky", 16'(led_error_a), 16'h1);
        send_a(8'h1C); qa.push_back(14'h001C);
        pop_a("t5_kept");
        pop_a("t5_idle_make");
        check("t5_empty", 16'(ev_empty_a), 16'h1);

        // ---- break-only reporting ----
        send_b(8'hE0); send_b(8'h75);
        check("t2_make_dropped", 16'(ev_empty_b), 16'h1);
        send_b(8'hE0); send_b(8'hF0); send_b(8'h75); qa.push_back(14'h0); qa.pop_back();
        qb.push_back(14'h375);
        check("t2_ctrl", 16'(ctrl_b), 16'h0);
        pop_b("t2_ext_brk");
        send_b(8'hE0); send_b(8'h14);
        check("t2_rctrl_on", 16'(ctrl_b), 16'h1);
        check("t2_rctrl_nopush", 16'(ev_empty_b), 16'h1);
        send_b(8'hE0); send_b(8'hF0); send_b(8'h14); qb.push_back(14'h0314);
        pop_b("t2_rctrl_brk");

        // ---- FIFO full, overflow, simultaneous push/pop ----
        for (int i = 1; i <= 4; i++) begin
            send_b(8'hF0); send_b(8'(i)); qb.push_back(14'(14'h200 | i));
        end
        check("t6_full", 16'(ev_full_b), 16'h1);
        check("t6_no_ovf", 16'(ev_overflow_b), 16'h0);
        send_b(8'hF0); send_b(8'h05);
        check("t6_ovf", 16'(ev_overflow_b), 16'h1);
        check("t6_still_full", 16'(ev_full_b), 16'h1);
        check("t6_head", 16'(ev_data_b), 16'(qb[0]));
        send_b(8'hF0);
        check("t6_pp_head", 16'(ev_data_b), 16'(qb.pop_front()));
        rx_data_b = 8'h06; rx_valid_b = 1'b1; ev_pop_b = 1'b1;
        tick();
        rx_valid_b = 1'b0; ev_pop_b = 1'b0;
        qb.push_back(14'h206);
        $display("b push+pop while full code=0x06");
        check("t6_pp_full", 16'(ev_full_b), 16'h1);
        check("t6_pp_ovf_clr", 16'(ev_overflow_b), 16'h0);
        for (int i = 0; i < 4; i++) pop_b($sformatf("t6_drain%0d", i));
        check("t6_empty", 16'(ev_empty_b), 16'h1);

        // ---- LED FSM disabled ----
        send_b(8'h58);
        check("t7_caps_b", 16'(caps_b), 16'h1);
        repeat (10) tick();
        check("t7_no_cmd", 16'(cmd_send_b), 16'h0);
        check("t7_nopush", 16'(ev_empty_b), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_event_decoder.md
Name: ps2_keyboard_event_decoder

Overview:
Parametrised successor to the text editor keyboard controller. Parses the byte stream from PS2_Controller into make/break events with E0-extended prefix support. Tracks modifier and lock state and buffers events in a FWFT FIFO for the editor core. Drives the keyboard lock LEDs through the PS2_Controller command handshake.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64
REPORT_MAKE, 1, 1 = push make and break events; 0 = push break events only
LED_UPDATE, 1, 1 = send ED+LED byte on every lock toggle; 0 = LED FSM disabled (cmd_send held 0)
ACK_TIMEOUT, 50000, sys_Clk cycles to wait for FA before abandoning an LED transfer

Ports:
sys_Clk  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-low reset
rx_data  input  8  received byte from PS2_Controller
rx_valid  input  1  one-cycle strobe, rx_data valid
cmd_byte  output  8  command byte to PS2_Controller
cmd_send  output  1  level request, held until cmd_sent
cmd_sent  input  1  one-cycle strobe, command transmitted
ev_data  output  14  {shift,ctrl,alt,caps_lock,brk,ext,code[7:0]} at FIFO head
ev_empty  output  1  FIFO empty
ev_pop  input  1  consume head entry; ignored when empty
ev_full  output  1  FIFO full
ev_overflow  output  1  sticky; event dropped while full
shift, ctrl, alt  output  1 each  modifier currently held (left OR right)
caps_lock, num_lock, scroll_lock  output  1 each  lock toggle state
led_error  output  1  sticky; LED transfer timed out

Behaviour:
- Reset low at a clock edge: all outputs 0, FIFO empty, parser in P_IDLE, LED FSM in L_IDLE, all held-key and pending flags 0.
- Parser states: P_IDLE, P_EXT (E0 seen), P_BRK (F0 seen), P_EXT_BRK (E0 F0 seen). Transitions apply only on rx_valid.
- E0 in P_IDLE -> P_EXT. F0 in P_IDLE -> P_BRK. F0 in P_EXT -> P_EXT_BRK.
- Control bytes FA, EE, FE, 00, FF, E1 in any parser state: no event, parser -> P_IDLE. FA also strobes an internal ack to the LED FSM.
- AA (BAT passed) in any state: parser -> P_IDLE; locks, modifiers and caps/num/scroll held flags cleared; LED FSM aborted to L_IDLE with the pending flag cleared. FIFO is preserved.
- Any other byte produces an event: brk = parser in P_BRK or P_EXT_BRK; ext = parser in P_EXT or P_EXT_BRK. Parser -> P_IDLE.
- Event latency: rx_valid at edge N -> ev_empty low and ev_data at head by N+1. Modifier and lock outputs also update at N+1. The ev_data modifier fields are the post-update values.
- Modifiers: shift = 12 or 59 held, non-extended. ctrl = 14, extended or not. alt = 11, extended or not. Left and right keys are tracked separately and ORed.
- Locks: 58 toggles caps, 77 toggles num, 7E toggles scroll; all non-extended, make only.
  - A make for a key whose held flag is set (typematic repeat) does not toggle.
  - Break clears the held flag.
- Push rule: a make is pushed only if REPORT_MAKE=1; a break is always pushed.
- FIFO:
  - Push while full drops the new event and sets ev_overflow; the FIFO is unchanged.
  - Simultaneous push and pop when full: both occur, no overflow.
  - Pop when empty: no effect.
  - ev_overflow clears on the first accepted pop.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- LED FSM states (only when LED_UPDATE=1): L_IDLE, L_CMD, L_ACK1, L_DATA, L_ACK2.
  - Any lock toggle sets a pending flag. L_IDLE with pending set: clear pending, -> L_CMD.
  - L_CMD: cmd_byte=ED, cmd_send=1; on cmd_sent drop cmd_send -> L_ACK1.
  - L_ACK1: FA -> L_DATA; ACK_TIMEOUT cycles without FA -> set led_error, -> L_IDLE.
  - L_DATA: cmd_byte={5'b0,caps_lock,num_lock,scroll_lock} sampled on entry, cmd_send=1; on cmd_sent drop -> L_ACK2.
  - L_ACK2: FA or timeout (timeout sets led_error) -> L_IDLE.
  - A toggle during a transfer sets pending, causing exactly one re-send afterwards.
- cmd_send is never asserted in the cycle after cmd_sent. The timeout counter resets on entry to each ACK state.

Test Plan:
1. Reset low 2 cycles then high; feed 1C, F0 1C -> two events: 0x01C (make), 0x21C (brk=1); ev_empty high after two pops.
2. Feed E0 75, E0 F0 75 with REPORT_MAKE=0 -> single event 0x375; ctrl stays 0.
3. Feed 12, 1C, F0 1C, F0 12 -> shift=1 from the cycle after 12; events 0x2012, 0x201C, 0x221C, then 0x0212 (shift=0 after release).
4. Feed 58, 58, F0 58 -> caps_lock=1 exactly once. LED FSM sends ED; respond cmd_sent then FA; then sends 0x04; respond cmd_sent and FA -> back to L_IDLE, led_error=0.
5. Withhold FA after ED -> led_error=1 after ACK_TIMEOUT cycles, cmd_send=0. Then feed AA -> caps_lock=0, parser idle, FIFO contents intact.
6. FIFO_DEPTH=4: push 5 events without popping -> ev_full=1, ev_overflow=1, head = first event. Push and pop in the same cycle while full -> count stays 4; ev_overflow clears.
